timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_unit.sv | 147 ++++++++++++++
 tb/tb_timer_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
//   Bus-programmable down-counting timer with one-shot and auto-reload modes
//   and a maskable, registered interrupt output.
//
//   Register map (addr):
//     00 CTRL   [0] Enable, [2:1] Mode (01 = auto-reload, else one-shot),
//               [3] IM (interrupt mask, 1 = irq enabled)
//     01 PRESET reload value for COUNT
//     10 COUNT  current count, read-only
//     11 unused, reads 0, writes ignored
//
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     addr      word select
//     we        write strobe, sampled at clk rising edge
//     data_in   write data
//     data_out  combinational read data for addr
//     irq       registered interrupt request (irq_flag & IM)
// -----------------------------------------------------------------------------
module timer_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_AUTO = 2'b01;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q, irq_d;

    logic        ctrl_wr;
    logic        preset_wr;
    logic        enable;
    logic [1:0]  mode;

    assign ctrl_wr   = we && (addr == 2'b00);
    assign preset_wr = we && (addr == 2'b01);
    assign enable    = ctrl_q[0];
    assign mode      = ctrl_q[2:1];

    // ------------------------------------------------------------------
    // State register (together with all other datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = LOAD;
            LOAD: state_d = CNT;
            CNT: begin
                if (!enable)
                    state_d = IDLE;
                else if (count_q == '0)
                    state_d = INT;
            end
            INT: state_d = (mode == MODE_AUTO) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // COUNT: only LOAD and a live, non-zero CNT change it, so it never wraps
        // and a PRESET write is seen only at the next LOAD.
        if (state_q == LOAD)
            count_d = preset_q;
        else if ((state_q == CNT) && enable && (count_q != '0))
            count_d = count_q - 32'd1;

        if (preset_wr)
            preset_d = data_in;

        // One-shot expiry drops Enable; a simultaneous bus write overrides it.
        if ((state_q == INT) && (mode != MODE_AUTO))
            ctrl_d[0] = 1'b0;
        if (ctrl_wr)
            ctrl_d = data_in[3:0];

        // irq_flag: clears (CTRL write, or auto-reload pulse end) lose to a set.
        if (ctrl_wr)
            irq_flag_d = 1'b0;
        if (irq_flag_q && (mode == MODE_AUTO))
            irq_flag_d = 1'b0;
        if (state_q == INT)
            irq_flag_d = 1'b1;
    end

    // irq is registered from the next-state flag and mask so it rises on the
    // same edge the flag sets, while still having no combinational bus path.
    assign irq_d = irq_flag_d & ctrl_d[3];
    assign irq   = irq_q;

    always_comb begin
        data_out = '0;
        unique case (addr)
            2'b00:   data_out = {28'b0, ctrl_q};
            2'b01:   data_out = preset_q;
            2'b10:   data_out = count_q;
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
//   Directed, self-checking bench for timer_unit. Inputs change 1 time unit
//   after a rising edge; "edge N" comments count edges from the CTRL write
//   that sets Enable (edge 0).
// -----------------------------------------------------------------------------
module tb_timer_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer_unit dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr    = a;
        data_in = d;
        we      = 1'b1;
        @(posedge clk);
        #1;
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = data_out;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst     = 1'b1;
        addr    = 2'b00;
        we      = 1'b0;
        data_in = '0;

        // ---------------- power-on reset ----------------
        step(2);
        chk("por_irq", {31'b0, irq}, 32'd0);
        chk_rd("por_ctrl", 2'b00, 32'd0);
        chk_rd("por_preset", 2'b01, 32'd0);
        chk_rd("por_count", 2'b10, 32'd0);
        rst = 1'b0;
        step(4);
        chk_rd("por_idle_count", 2'b10, 32'd0);
        chk("por_idle_irq", {31'b0, irq}, 32'd0);

        // ---------------- one-shot, PRESET=3, CTRL=0x9 ----------------
        wr(2'b01, 32'd3);
        wr(2'b00, 32'h9);                       // edge 0
        step(2);                                // edge 2: LOAD
        chk_rd("os_cnt3", 2'b10, 32'd3);
        step(1);
        chk_rd("os_cnt2", 2'b10, 32'd2);
        step(1);
        chk_rd("os_cnt1", 2'b10, 32'd1);
        step(1);
        chk_rd("os_cnt0", 2'b10, 32'd0);
        step(1);                                // edge 6: in INT
        chk("os_irq_e6", {31'b0, irq}, 32'd0);
        step(1);                                // edge 7
        chk("os_irq_e7", {31'b0, irq}, 32'd1);
        chk_rd("os_ctrl_after", 2'b00, 32'h8);
        step(3);
        chk("os_irq_hold", {31'b0, irq}, 32'd1);
        chk_rd("os_count_hold", 2'b10, 32'd0);
        wr(2'b00, 32'h8);
        chk("os_irq_clr", {31'b0, irq}, 32'd0);
        step(2);
        chk("os_irq_stay0", {31'b0, irq}, 32'd0);

        // ---------------- auto-reload, PRESET=2, CTRL=0xB ----------------
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'hB);                       // edge 0
        step(5);
        chk("ar_irq_e5", {31'b0, irq}, 32'd0);
        step(1);
        chk("ar_irq_e6", {31'b0, irq}, 32'd1);
        chk_rd("ar_ctrl_e6", 2'b00, 32'hB);
        step(1);
        chk("ar_irq_e7", {31'b0, irq}, 32'd0);
        chk_rd("ar_count_e7", 2'b10, 32'd2);
        step(3);
        chk("ar_irq_e10", {31'b0, irq}, 32'd0);
        step(1);
        chk("ar_irq_e11", {31'b0, irq}, 32'd1);
        step(1);
        chk("ar_irq_e12", {31'b0, irq}, 32'd0);
        step(4);
        chk("ar_irq_e16", {31'b0, irq}, 32'd1);
        chk_rd("ar_ctrl_e16", 2'b00, 32'hB);

        // ---------------- masked one-shot, PRESET=1, CTRL=0x1 ----------------
        do_reset();
        wr(2'b01, 32'd1);
        wr(2'b00, 32'h1);                       // edge 0
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk($sformatf("mask_irq_e%0d", i), {31'b0, irq}, 32'd0);
        end
        chk_rd("mask_ctrl_after", 2'b00, 32'h0);
        wr(2'b00, 32'h8);
        chk("mask_irq_im", {31'b0, irq}, 32'd0);
        step(2);
        chk("mask_irq_im2", {31'b0, irq}, 32'd0);

        // ---------------- PRESET=0 latency ----------------
        do_reset();
        wr(2'b00, 32'h9);                       // edge 0, PRESET=0
        step(3);
        chk("p0_irq_e3", {31'b0, irq}, 32'd0);
        step(1);
        chk("p0_irq_e4", {31'b0, irq}, 32'd1);

        // ---------------- collision: CTRL write on the flag-set edge ----------------
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h9);                       // edge 0
        step(5);                                // edge 5: in INT
        wr(2'b00, 32'h8);                       // edge 6: set vs clear
        chk("col_irq_set", {31'b0, irq}, 32'd1);
        chk_rd("col_ctrl", 2'b00, 32'h8);
        step(2);
        chk("col_irq_hold", {31'b0, irq}, 32'd1);

        // ---------------- disable mid-count, PRESET=10 ----------------
        do_reset();
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h1);                       // edge 0
        step(4);
        chk_rd("dis_cnt8", 2'b10, 32'd8);
        wr(2'b01, 32'd100);                     // PRESET write during CNT
        chk_rd("dis_preset_cnt7", 2'b10, 32'd7);
        step(1);
        chk_rd("dis_cnt6", 2'b10, 32'd6);
        wr(2'b00, 32'h0);
        chk_rd("dis_cnt5_write", 2'b10, 32'd5);
        step(3);
        chk_rd("dis_frozen", 2'b10, 32'd5);
        wr(2'b10, 32'hDEAD_BEEF);
        wr(2'b11, 32'hCAFE_F00D);
        chk_rd("ign_ctrl", 2'b00, 32'h0);
        chk_rd("ign_preset", 2'b01, 32'd100);
        chk_rd("ign_count", 2'b10, 32'd5);
        chk_rd("ign_addr3", 2'b11, 32'd0);
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h1);                       // re-enable: W
        step(1);                                // LOAD
        chk_rd("reen_before", 2'b10, 32'd5);
        step(1);
        chk_rd("reen_reload", 2'b10, 32'd10);
        wr(2'b00, 32'h9);                       // keeps Enable=1
        chk_rd("keep_cnt9", 2'b10, 32'd9);
        step(1);
        chk_rd("keep_cnt8", 2'b10, 32'd8);
        step(1);
        chk_rd("keep_cnt7", 2'b10, 32'd7);

        // ---------------- reset mid-count (COUNT=7) ----------------
        #2;
        rst = 1'b1;
        #1;
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk_rd("rst_ctrl", 2'b00, 32'd0);
        chk_rd("rst_preset", 2'b01, 32'd0);
        chk_rd("rst_count", 2'b10, 32'd0);
        step(1);
        rst = 1'b0;
        step(5);
        chk_rd("rst_idle_count", 2'b10, 32'd0);
        chk("rst_idle_irq", {31'b0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
